// File: rtl/ex_mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op codes, FSM
// state encoding and divide-by-zero result constant.
package mdu_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    localparam logic [31:0] DIV_BY_ZERO_LO = 32'hFFFF_FFFF;
    localparam int          MDU_ITER       = 32;

    function automatic logic mdu_is_arith(input logic [3:0] op);
        return (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

endpackage

// File: rtl/ex_mdu_if.sv
// ID/EX-side connection of the multiply/divide unit: op and operands in,
// stall request, move-from read data and architectural HI/LO out.
interface ex_mdu_if;
    logic [3:0]  mdu_op_i;
    logic [31:0] mdu_a_i;
    logic [31:0] mdu_b_i;
    logic        flush_i;
    logic        mdu_stall_o;
    logic [31:0] mdu_result_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output mdu_op_i, mdu_a_i, mdu_b_i, flush_i,
        input  mdu_stall_o, mdu_result_o, hi_o, lo_o
    );

    modport slave (
        input  mdu_op_i, mdu_a_i, mdu_b_i, flush_i,
        output mdu_stall_o, mdu_result_o, hi_o, lo_o
    );
endinterface

// File: rtl/ex_mdu_div.sv
// Restoring unsigned divider, one quotient bit per cycle. Quotient and
// remainder outputs carry the post-step values and are valid while o_done is high.
module ex_mdu_div #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder
);
    localparam int CNT_W = $clog2(ITER);

    logic             r_busy;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_rem;
    logic [31:0]      r_quo;
    logic [31:0]      r_dvs;

    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_rem_nxt;
    logic [31:0] w_quo_nxt;

    // Partial remainder stays below the divisor, so bit 32 of the difference is the borrow.
    assign w_shift   = {r_rem, r_quo[31]};
    assign w_diff    = w_shift - {1'b0, r_dvs};
    assign w_ge      = ~w_diff[32];
    assign w_rem_nxt = w_ge ? w_diff[31:0] : w_shift[31:0];
    assign w_quo_nxt = {r_quo[30:0], w_ge};

    assign o_busy      = r_busy;
    assign o_done      = r_busy && (r_count == CNT_W'(ITER - 1));
    assign o_quotient  = w_quo_nxt;
    assign o_remainder = w_rem_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy  <= 1'b0;
            r_count <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
        end else if (i_abort) begin
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_busy  <= 1'b1;
            r_count <= '0;
            r_rem   <= '0;
            r_quo   <= i_dividend;
            r_dvs   <= i_divisor;
        end else if (r_busy) begin
            r_rem   <= w_rem_nxt;
            r_quo   <= w_quo_nxt;
            r_count <= r_count + CNT_W'(1);
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit: owns HI/LO, sequences iterative MULT/DIV and
// holds the pipeline while an operation is in flight.
//
// state | meaning
// IDLE  | accepts arith ops (issue), MTHI/MTLO writes, MFHI/MFLO reads
// BUSY  | one multiply/divide step per cycle, stall held
// DONE  | HI/LO committed, stall released, presented op not re-issued
module ex_mdu
    import mdu_pkg::*;
#(
    parameter bit MUL_FAST = 1'b0,
    parameter int ITER     = MDU_ITER
) (
    input  logic    clk,
    input  logic    reset,
    ex_mdu_if.slave bus
);
    localparam int CNT_W = $clog2(ITER);

    mdu_state_e       r_state;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [3:0]       r_op;
    logic [31:0]      r_a_abs;
    logic [31:0]      r_b_abs;
    logic [31:0]      r_a_orig;
    logic             r_sign_a;
    logic             r_sign_b;
    logic             r_div0;
    logic [63:0]      r_prod;

    logic [3:0]  w_op;
    logic        w_issue;
    logic        w_signed_in;
    logic [31:0] w_a_abs;
    logic [31:0] w_b_abs;
    logic        w_busy_div;
    logic        w_last;
    logic        w_neg;
    logic [32:0] w_sum;
    logic [63:0] w_prod_step;
    logic [63:0] w_prod_raw;
    logic [63:0] w_prod_fix;
    logic        w_div_busy;
    logic        w_div_done;
    logic [31:0] w_div_q;
    logic [31:0] w_div_r;
    logic [31:0] w_hi_commit;
    logic [31:0] w_lo_commit;

    assign w_op        = bus.mdu_op_i;
    assign w_issue     = (r_state == ST_IDLE) && mdu_is_arith(w_op) && !bus.flush_i;
    assign w_signed_in = (w_op == OP_MULT) || (w_op == OP_DIV);
    assign w_a_abs     = (w_signed_in && bus.mdu_a_i[31]) ? -bus.mdu_a_i : bus.mdu_a_i;
    assign w_b_abs     = (w_signed_in && bus.mdu_b_i[31]) ? -bus.mdu_b_i : bus.mdu_b_i;
    assign w_busy_div  = (r_op == OP_DIV) || (r_op == OP_DIVU);
    assign w_neg       = r_sign_a ^ r_sign_b;

    // Shift-add: upper half accumulates |a|, lower half holds the unconsumed multiplier bits.
    assign w_sum       = {1'b0, r_prod[63:32]} + (r_prod[0] ? {1'b0, r_a_abs} : 33'd0);
    assign w_prod_step = {w_sum, r_prod[31:1]};
    assign w_prod_raw  = MUL_FAST ? ({32'd0, r_a_abs} * {32'd0, r_b_abs}) : w_prod_step;
    assign w_prod_fix  = w_neg ? -w_prod_raw : w_prod_raw;

    assign w_last = w_busy_div ? (w_div_busy && w_div_done)
                               : (MUL_FAST || (r_count == CNT_W'(ITER - 1)));

    always_comb begin
        w_hi_commit = w_prod_fix[63:32];
        w_lo_commit = w_prod_fix[31:0];
        if (w_busy_div) begin
            if (r_div0) begin
                w_hi_commit = r_a_orig;
                w_lo_commit = DIV_BY_ZERO_LO;
            end else begin
                w_hi_commit = r_sign_a ? -w_div_r : w_div_r;
                w_lo_commit = w_neg ? -w_div_q : w_div_q;
            end
        end
    end

    ex_mdu_div #(
        .ITER (ITER)
    ) u_div (
        .clk         (clk),
        .reset       (reset),
        .i_start     (w_issue && ((w_op == OP_DIV) || (w_op == OP_DIVU))),
        .i_abort     ((r_state == ST_BUSY) && bus.flush_i),
        .i_dividend  (w_a_abs),
        .i_divisor   (w_b_abs),
        .o_busy      (w_div_busy),
        .o_done      (w_div_done),
        .o_quotient  (w_div_q),
        .o_remainder (w_div_r)
    );

    assign bus.mdu_stall_o  = (r_state == ST_BUSY) || w_issue;
    assign bus.mdu_result_o = (w_op == OP_MFHI) ? r_hi :
                              (w_op == OP_MFLO) ? r_lo : 32'd0;
    assign bus.hi_o         = r_hi;
    assign bus.lo_o         = r_lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_op     <= OP_NOP;
            r_a_abs  <= '0;
            r_b_abs  <= '0;
            r_a_orig <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_div0   <= 1'b0;
            r_prod   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_issue) begin
                        r_state  <= ST_BUSY;
                        r_count  <= '0;
                        r_op     <= w_op;
                        r_a_abs  <= w_a_abs;
                        r_b_abs  <= w_b_abs;
                        r_a_orig <= bus.mdu_a_i;
                        r_sign_a <= w_signed_in && bus.mdu_a_i[31];
                        r_sign_b <= w_signed_in && bus.mdu_b_i[31];
                        r_div0   <= (bus.mdu_b_i == 32'd0);
                        r_prod   <= {32'd0, w_b_abs};
                    end else if (!bus.flush_i) begin
                        if (w_op == OP_MTHI) r_hi <= bus.mdu_a_i;
                        if (w_op == OP_MTLO) r_lo <= bus.mdu_a_i;
                    end
                end
                ST_BUSY: begin
                    // A kill wins over a commit landing on the same edge.
                    if (bus.flush_i) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                        r_prod  <= w_prod_step;
                        if (w_last) begin
                            r_hi    <= w_hi_commit;
                            r_lo    <= w_lo_commit;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    if (!bus.flush_i) begin
                        if (w_op == OP_MTHI) r_hi <= bus.mdu_a_i;
                        if (w_op == OP_MTLO) r_lo <= bus.mdu_a_i;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mdu.sv
// Randomized bench for ex_mdu against an arithmetic HI/LO reference model,
// plus directed stall, flush and reset scenarios.
module tb_ex_mdu;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic reset;

    ex_mdu_if bus();

    ex_mdu #(
        .MUL_FAST (1'b0),
        .ITER     (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] corner [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic fl);
        @(posedge clk);
        #1;
        bus.mdu_op_i = op;
        bus.mdu_a_i  = a;
        bus.mdu_b_i  = b;
        bus.flush_i  = fl;
    endtask

    // Reference: MIPS HI/LO semantics computed directly with wide arithmetic.
    function automatic void mdl(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sp;
        logic [63:0]        up;
        int                 sa;
        int                 sb;
        sa = a;
        sb = b;
        case (op)
            OP_MULT: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                m_hi = sp[63:32];
                m_lo = sp[31:0];
            end
            OP_MULTU: begin
                up = {32'd0, a} * {32'd0, b};
                m_hi = up[63:32];
                m_lo = up[31:0];
            end
            OP_DIV: begin
                if (b == 32'd0) begin
                    m_hi = a;
                    m_lo = 32'hFFFF_FFFF;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_hi = 32'd0;
                    m_lo = 32'h8000_0000;
                end else begin
                    m_lo = sa / sb;
                    m_hi = sa % sb;
                end
            end
            OP_DIVU: begin
                if (b == 32'd0) begin
                    m_hi = a;
                    m_lo = 32'hFFFF_FFFF;
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            OP_MTHI: m_hi = a;
            OP_MTLO: m_lo = a;
            default: ;
        endcase
    endfunction

    task automatic wait_done(inout int n);
        while (bus.mdu_stall_o && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        drive(op, a, b, 1'b0);
        @(negedge clk);
        wait_done(n);
        mdl(op, a, b);
        chk("stall_len", 64'(n), 64'd33);
        chk("hi", bus.hi_o, m_hi);
        chk("lo", bus.lo_o, m_lo);
        drive(OP_NOP, 32'd0, 32'd0, 1'b0);
    endtask

    function automatic logic [31:0] pick();
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 5)];
        return $urandom();
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        bus.mdu_op_i = OP_NOP;
        bus.mdu_a_i  = '0;
        bus.mdu_b_i  = '0;
        bus.flush_i  = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        chk("rst_stall", bus.mdu_stall_o, 0);
        chk("rst_result", bus.mdu_result_o, 0);
        chk("rst_hi", bus.hi_o, 0);
        chk("rst_lo", bus.lo_o, 0);

        run_op(OP_MULT, 32'hFFFF_FFFF, 32'd2);
        chk("mult_hi_lit", bus.hi_o, 32'hFFFF_FFFF);
        chk("mult_lo_lit", bus.lo_o, 32'hFFFF_FFFE);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        chk("multu_hi_lit", bus.hi_o, 32'h1);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        chk("div_lo_lit", bus.lo_o, 32'hFFFF_FFFD);
        run_op(OP_DIVU, 32'd100, 32'd7);
        chk("divu_lo_lit", bus.lo_o, 32'd14);
        run_op(OP_DIVU, 32'd5, 32'd0);
        chk("div0_lo_lit", bus.lo_o, 32'hFFFF_FFFF);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("divovf_lo_lit", bus.lo_o, 32'h8000_0000);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd0);

        // MFLO presented while a MULT is in flight
        n = 0;
        drive(OP_MULT, 32'd3, 32'd4, 1'b0);
        @(negedge clk);
        if (bus.mdu_stall_o) n = 1;
        drive(OP_MFLO, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        wait_done(n);
        mdl(OP_MULT, 32'd3, 32'd4);
        chk("mf_busy_stall_len", 64'(n), 64'd33);
        chk("mf_busy_result", bus.mdu_result_o, 32'd12);
        drive(OP_MFLO, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        chk("mf_no_reissue", bus.mdu_stall_o, 0);
        chk("mf_idle_result", bus.mdu_result_o, 32'd12);

        // MTHI presented while busy lands after the commit
        n = 0;
        drive(OP_MULTU, 32'h0001_0000, 32'h0003_0000, 1'b0);
        @(negedge clk);
        if (bus.mdu_stall_o) n = 1;
        drive(OP_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0);
        @(negedge clk);
        wait_done(n);
        mdl(OP_MULTU, 32'h0001_0000, 32'h0003_0000);
        chk("mt_busy_stall_len", 64'(n), 64'd33);
        chk("mt_busy_commit_hi", bus.hi_o, m_hi);
        drive(OP_NOP, 32'd0, 32'd0, 1'b0);
        mdl(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
        @(negedge clk);
        chk("mt_done_hi", bus.hi_o, m_hi);
        chk("mt_done_lo", bus.lo_o, m_lo);

        // Flush in the issue cycle and mid-divide
        drive(OP_MTHI, 32'h0000_AAAA, 32'd0, 1'b0);
        drive(OP_MTLO, 32'h0000_5555, 32'd0, 1'b0);
        drive(OP_DIV, 32'd1000, 32'd3, 1'b1);
        @(negedge clk);
        chk("flush_issue_stall", bus.mdu_stall_o, 0);
        drive(OP_NOP, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        chk("flush_issue_stall2", bus.mdu_stall_o, 0);
        drive(OP_DIV, 32'd1000, 32'd3, 1'b0);
        repeat (11) @(posedge clk);
        #1 bus.flush_i = 1'b1;
        @(negedge clk);
        chk("flush_busy_stall", bus.mdu_stall_o, 1);
        drive(OP_NOP, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        chk("flush_after_stall", bus.mdu_stall_o, 0);
        chk("flush_hi", bus.hi_o, 32'h0000_AAAA);
        chk("flush_lo", bus.lo_o, 32'h0000_5555);

        // Reset mid-multiply
        drive(OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        repeat (21) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.mdu_op_i = OP_NOP;
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        chk("rst_mid_stall", bus.mdu_stall_o, 0);
        chk("rst_mid_hi", bus.hi_o, 0);
        chk("rst_mid_lo", bus.lo_o, 0);
        drive(OP_MTLO, 32'h1234, 32'd0, 1'b0);
        mdl(OP_MTLO, 32'h1234, 32'd0);
        drive(OP_MFLO, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        chk("mtlo_mflo", bus.mdu_result_o, 32'h1234);

        // Random op mix
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = pick();
            b  = pick();
            if (mdu_is_arith(op)) begin
                run_op(op, a, b);
            end else if (op == OP_MFHI || op == OP_MFLO) begin
                drive(op, a, b, 1'b0);
                @(negedge clk);
                chk("rnd_mf_stall", bus.mdu_stall_o, 0);
                chk("rnd_mf_result", bus.mdu_result_o, (op == OP_MFHI) ? m_hi : m_lo);
            end else begin
                drive(op, a, b, 1'b0);
                @(negedge clk);
                chk("rnd_stall", bus.mdu_stall_o, 0);
                chk("rnd_result", bus.mdu_result_o, 0);
                mdl(op, a, b);
                drive(OP_NOP, 32'd0, 32'd0, 1'b0);
                @(negedge clk);
                chk("rnd_hi", bus.hi_o, m_hi);
                chk("rnd_lo", bus.lo_o, m_lo);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
